// File: rtl/mesh_pkg.sv
// Shared definitions for the XY mesh router: port indices, coordinate width
// helper, header field extraction and the dimension-ordered route decision.
package mesh_pkg;

  // Port indices; also the requester order seen by every output arbiter.
  localparam int N         = 0;
  localparam int E         = 1;
  localparam int S         = 2;
  localparam int W         = 3;
  localparam int PE        = 4;
  localparam int NUM_PORTS = 5;

  // Widest packet the header helpers accept.
  localparam int MAX_PKT_W = 1024;

  typedef logic [2:0] port_idx_t;

  // Coordinate field width: clog2 of the mesh dimension, never below one bit.
  function automatic int coord_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // dest_x occupies the top xw bits of the packet.
  function automatic logic [31:0] hdr_dest_x(input logic [MAX_PKT_W-1:0] pkt,
                                             input int pkt_w, input int xw);
    logic [MAX_PKT_W-1:0] sh;
    sh = pkt >> (pkt_w - xw);
    return sh[31:0] & ((32'd1 << xw) - 32'd1);
  endfunction

  // dest_y occupies the yw bits directly below dest_x.
  function automatic logic [31:0] hdr_dest_y(input logic [MAX_PKT_W-1:0] pkt,
                                             input int pkt_w, input int xw,
                                             input int yw);
    logic [MAX_PKT_W-1:0] sh;
    sh = pkt >> (pkt_w - xw - yw);
    return sh[31:0] & ((32'd1 << yw) - 32'd1);
  endfunction

  // X first, then Y; a packet at its destination goes to the local PE.
  function automatic port_idx_t route_port(input logic [31:0] dx, input logic [31:0] dy,
                                           input logic [31:0] rx, input logic [31:0] ry);
    if (dx > rx)      return port_idx_t'(E);
    else if (dx < rx) return port_idx_t'(W);
    else if (dy > ry) return port_idx_t'(S);
    else if (dy < ry) return port_idx_t'(N);
    else              return port_idx_t'(PE);
  endfunction

  // False when the chosen output points off the mesh edge.
  function automatic logic has_neighbour(input port_idx_t p,
                                         input logic [31:0] rx, input logic [31:0] ry,
                                         input int mesh_x, input int mesh_y);
    case (p)
      port_idx_t'(N): return ry != 32'd0;
      port_idx_t'(E): return rx != 32'(mesh_x - 1);
      port_idx_t'(S): return ry != 32'(mesh_y - 1);
      port_idx_t'(W): return rx != 32'd0;
      default:        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mesh_router_xy_if.sv
// Five-port link bundle of one router tile. Signal names are port prefix
// (n, e, s, w, pe) plus si/ri/di on the input side and so/ro/do on the output.
interface mesh_router_xy_if #(
  parameter int PACKET_WIDTH = 64
);
  logic                    nsi, nri, nso, nro;
  logic [PACKET_WIDTH-1:0] ndi, ndo;
  logic                    esi, eri, eso, ero;
  logic [PACKET_WIDTH-1:0] edi, edo;
  logic                    ssi, sri, sso, sro;
  logic [PACKET_WIDTH-1:0] sdi, sdo;
  logic                    wsi, wri, wso, wro;
  logic [PACKET_WIDTH-1:0] wdi, wdo;
  logic                    pesi, peri, peso, pero;
  logic [PACKET_WIDTH-1:0] pedi, pedo;

  // Router side.
  modport slave (
    input  nsi, ndi, nro, esi, edi, ero, ssi, sdi, sro, wsi, wdi, wro, pesi, pedi, pero,
    output nri, nso, ndo, eri, eso, edo, sri, sso, sdo, wri, wso, wdo, peri, peso, pedo
  );

  // Neighbour / NIC side.
  modport master (
    output nsi, ndi, nro, esi, edi, ero, ssi, sdi, sro, wsi, wdi, wro, pesi, pedi, pero,
    input  nri, nso, ndo, eri, eso, edo, sri, sso, sdo, wri, wso, wdo, peri, peso, pedo
  );
endinterface

// File: rtl/router_in_fifo.sv
// Per-input packet FIFO. Full is a flop, so a full FIFO refuses a push even
// in a cycle where it also pops.
module router_in_fifo #(
  parameter int PACKET_WIDTH = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [PACKET_WIDTH-1:0] din,
  output logic                    full,
  output logic                    empty,
  output logic [PACKET_WIDTH-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [PACKET_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    full_q, full_d;
  logic                    do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);
  assign full    = full_q;
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];

  // Next pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == DEPTH_C);
  end

  // Control state; reset empties the FIFO at once.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Packet storage.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the cleared count marks every entry invalid.
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mesh_router_xy.sv
// Five-port XY mesh router tile: per-input FIFOs, dimension-ordered routing,
// off-edge drop with a saturating counter, and one round-robin arbiter plus
// output register per output port.
module mesh_router_xy
  import mesh_pkg::*;
#(
  parameter  int PACKET_WIDTH = 64,
  parameter  int MESH_X       = 4,
  parameter  int MESH_Y       = 4,
  parameter  int FIFO_DEPTH   = 4,
  localparam int XW           = coord_width(MESH_X),
  localparam int YW           = coord_width(MESH_Y)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XW-1:0]     router_x,
  input  logic [YW-1:0]     router_y,
  mesh_router_xy_if.slave   bus,
  output logic              polarity_out,
  output logic [7:0]        drop_count
);

  logic [NUM_PORTS-1:0]    in_valid, out_ready;
  logic [PACKET_WIDTH-1:0] in_data [NUM_PORTS];

  logic [NUM_PORTS-1:0]    fifo_full, fifo_empty, fifo_pop;
  logic [PACKET_WIDTH-1:0] fifo_head [NUM_PORTS];

  port_idx_t               route_dir [NUM_PORTS];
  logic [NUM_PORTS-1:0]    drop;
  logic [NUM_PORTS-1:0]    req [NUM_PORTS];   // req[output][input]

  logic [NUM_PORTS-1:0]    gnt_valid;
  port_idx_t               gnt_idx [NUM_PORTS];

  logic [NUM_PORTS-1:0]    out_valid_q, out_valid_d;
  logic [PACKET_WIDTH-1:0] out_data_q [NUM_PORTS];
  logic [PACKET_WIDTH-1:0] out_data_d [NUM_PORTS];
  port_idx_t               rr_ptr_q [NUM_PORTS];
  port_idx_t               rr_ptr_d [NUM_PORTS];

  logic [7:0]              drop_count_q, drop_count_d;
  logic                    polarity_q, polarity_d;

  // Flatten the interface into port-indexed arrays.
  assign in_valid  = {bus.pesi, bus.wsi, bus.ssi, bus.esi, bus.nsi};
  assign out_ready = {bus.pero, bus.wro, bus.sro, bus.ero, bus.nro};
  assign in_data[N]  = bus.ndi;
  assign in_data[E]  = bus.edi;
  assign in_data[S]  = bus.sdi;
  assign in_data[W]  = bus.wdi;
  assign in_data[PE] = bus.pedi;

  assign bus.nri  = ~fifo_full[N];
  assign bus.eri  = ~fifo_full[E];
  assign bus.sri  = ~fifo_full[S];
  assign bus.wri  = ~fifo_full[W];
  assign bus.peri = ~fifo_full[PE];

  assign bus.nso  = out_valid_q[N];
  assign bus.eso  = out_valid_q[E];
  assign bus.sso  = out_valid_q[S];
  assign bus.wso  = out_valid_q[W];
  assign bus.peso = out_valid_q[PE];
  assign bus.ndo  = out_data_q[N];
  assign bus.edo  = out_data_q[E];
  assign bus.sdo  = out_data_q[S];
  assign bus.wdo  = out_data_q[W];
  assign bus.pedo = out_data_q[PE];

  assign drop_count   = drop_count_q;
  assign polarity_out = polarity_q;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_in_fifo
    router_in_fifo #(
      .PACKET_WIDTH (PACKET_WIDTH),
      .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid[g]),
      .pop   (fifo_pop[g]),
      .din   (in_data[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g]),
      .head  (fifo_head[g])
    );
  end

  // Route every FIFO head; heads aimed off the mesh edge are dropped instead of requesting.
  always_comb begin
    drop = '0;
    for (int o = 0; o < NUM_PORTS; o++) req[o] = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      route_dir[i] = route_port(
        hdr_dest_x(MAX_PKT_W'(fifo_head[i]), PACKET_WIDTH, XW),
        hdr_dest_y(MAX_PKT_W'(fifo_head[i]), PACKET_WIDTH, XW, YW),
        32'(router_x), 32'(router_y));
      if (!fifo_empty[i]) begin
        if (has_neighbour(route_dir[i], 32'(router_x), 32'(router_y), MESH_X, MESH_Y))
          req[route_dir[i]][i] = 1'b1;
        else
          drop[i] = 1'b1;
      end
    end
  end

  // Round-robin pick per output, searching from the port after the last winner.
  always_comb begin
    logic [3:0] sum;
    port_idx_t  cand;
    sum  = '0;
    cand = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_valid[o] = 1'b0;
      gnt_idx[o]   = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
        sum = {1'b0, rr_ptr_q[o]} + 4'(k);
        if (sum >= 4'(NUM_PORTS)) sum = sum - 4'(NUM_PORTS);
        cand = sum[2:0];
        if (!gnt_valid[o] && req[o][cand]) begin
          gnt_valid[o] = 1'b1;
          gnt_idx[o]   = cand;
        end
      end
    end
  end

  // Output register load, winner pops and pointer advance; registers hold under backpressure.
  always_comb begin
    fifo_pop = drop;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_valid_d[o] = out_valid_q[o];
      out_data_d[o]  = out_data_q[o];
      rr_ptr_d[o]    = rr_ptr_q[o];
      if (!out_valid_q[o] || out_ready[o]) begin
        out_valid_d[o] = gnt_valid[o];
        if (gnt_valid[o]) begin
          out_data_d[o]         = fifo_head[gnt_idx[o]];
          rr_ptr_d[o]           = gnt_idx[o];
          fifo_pop[gnt_idx[o]]  = 1'b1;
        end
      end
    end
  end

  // Saturating drop counter (several heads may drop on one edge) and polarity toggle.
  always_comb begin
    logic [3:0] drop_sum;
    logic [8:0] drop_total;
    drop_sum = '0;
    for (int i = 0; i < NUM_PORTS; i++) drop_sum = drop_sum + 4'(drop[i]);
    drop_total   = {1'b0, drop_count_q} + 9'(drop_sum);
    drop_count_d = (drop_total > 9'd255) ? 8'hFF : drop_total[7:0];
    polarity_d   = ~polarity_q;
  end

  // Output registers, arbiter pointers, drop counter and polarity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_valid_q[o] <= 1'b0;
        out_data_q[o]  <= '0;
        rr_ptr_q[o]    <= port_idx_t'(PE);
      end
      drop_count_q <= '0;
      polarity_q   <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        out_valid_q[o] <= out_valid_d[o];
        out_data_q[o]  <= out_data_d[o];
        rr_ptr_q[o]    <= rr_ptr_d[o];
      end
      drop_count_q <= drop_count_d;
      polarity_q   <= polarity_d;
    end
  end

endmodule

// File: tb/tb_mesh_router_xy.sv
// Directed bench: a 4x4 tile for routing, arbitration, backpressure and reset;
// a 3x3 tile, where off-edge destinations exist, for drops and saturation.
module tb_mesh_router_xy;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rx, ry, rx2, ry2;
  logic       pol, pol2;
  logic [7:0] dc, dc2;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] q [5];

  mesh_router_xy_if #(.PACKET_WIDTH(64)) bus  ();
  mesh_router_xy_if #(.PACKET_WIDTH(64)) bus2 ();

  mesh_router_xy #(.PACKET_WIDTH(64), .MESH_X(4), .MESH_Y(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .router_x(rx), .router_y(ry), .bus(bus),
    .polarity_out(pol), .drop_count(dc));

  mesh_router_xy #(.PACKET_WIDTH(64), .MESH_X(3), .MESH_Y(3), .FIFO_DEPTH(4)) dut_edge (
    .clk(clk), .reset(reset), .router_x(rx2), .router_y(ry2), .bus(bus2),
    .polarity_out(pol2), .drop_count(dc2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance past one rising edge; inputs and samples both sit 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pkt(input logic [1:0] dx, input logic [1:0] dy,
                                      input logic [59:0] pl);
    return {dx, dy, pl};
  endfunction

  initial begin
    reset = 1'b0;
    rx = 2'd1; ry = 2'd1; rx2 = 2'd2; ry2 = 2'd0;
    bus.nsi = 0; bus.esi = 0; bus.ssi = 0; bus.wsi = 0; bus.pesi = 0;
    bus.ndi = '0; bus.edi = '0; bus.sdi = '0; bus.wdi = '0; bus.pedi = '0;
    bus.nro = 1; bus.ero = 1; bus.sro = 1; bus.wro = 1; bus.pero = 1;
    bus2.nsi = 0; bus2.esi = 0; bus2.ssi = 0; bus2.wsi = 0; bus2.pesi = 0;
    bus2.ndi = '0; bus2.edi = '0; bus2.sdi = '0; bus2.wdi = '0; bus2.pedi = '0;
    bus2.nro = 1; bus2.ero = 1; bus2.sro = 1; bus2.wro = 1; bus2.pero = 1;

    // Reset values, then polarity toggling after release.
    step(); step();
    check("rst_ri", 64'({bus.nri, bus.eri, bus.sri, bus.wri, bus.peri}), 64'h1F);
    check("rst_so", 64'({bus.nso, bus.eso, bus.sso, bus.wso, bus.peso}), 64'h0);
    check("rst_pedo", bus.pedo, 64'h0);
    check("rst_drop", 64'(dc), 64'd0);
    check("rst_pol", 64'(pol), 64'd0);
    reset = 1'b1;
    step(); check("pol_1", 64'(pol), 64'd1);
    step(); check("pol_2", 64'(pol), 64'd0);
    step(); check("pol_3", 64'(pol), 64'd1);

    // Zero-load routing at (1,1): east, south, local.
    q[0] = pkt(2'd3, 2'd1, 60'hABC_0001);
    bus.pesi = 1; bus.pedi = q[0];
    step(); bus.pesi = 0;
    check("east_early", 64'(bus.eso), 64'd0);
    step();
    check("east_valid", 64'(bus.eso), 64'd1);
    check("east_data", bus.edo, q[0]);
    check("east_only", 64'({bus.nso, bus.sso, bus.wso, bus.peso}), 64'd0);
    step();

    q[1] = pkt(2'd1, 2'd2, 60'hABC_0002);
    bus.pesi = 1; bus.pedi = q[1];
    step(); bus.pesi = 0; step();
    check("south_valid", 64'(bus.sso), 64'd1);
    check("south_data", bus.sdo, q[1]);
    step();

    q[2] = pkt(2'd1, 2'd1, 60'hABC_0003);
    bus.pesi = 1; bus.pedi = q[2];
    step(); bus.pesi = 0; step();
    check("local_valid", 64'(bus.peso), 64'd1);
    check("local_data", bus.pedo, q[2]);
    step();

    // Round robin into pe: n, e, s, w all at once -> served n, e, s, w.
    q[0] = pkt(2'd1, 2'd1, 60'h100); q[1] = pkt(2'd1, 2'd1, 60'h101);
    q[2] = pkt(2'd1, 2'd1, 60'h102); q[3] = pkt(2'd1, 2'd1, 60'h103);
    bus.nsi = 1; bus.ndi = q[0]; bus.esi = 1; bus.edi = q[1];
    bus.ssi = 1; bus.sdi = q[2]; bus.wsi = 1; bus.wdi = q[3];
    step();
    bus.nsi = 0; bus.esi = 0; bus.ssi = 0; bus.wsi = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr1_valid", 64'(bus.peso), 64'd1);
      check("rr1_data", bus.pedo, q[i]);
    end
    step();
    check("rr1_idle", 64'(bus.peso), 64'd0);

    // Second round: last winner was w, so pe comes first, then n, then s.
    q[0] = pkt(2'd1, 2'd1, 60'h200); q[1] = pkt(2'd1, 2'd1, 60'h201);
    q[2] = pkt(2'd1, 2'd1, 60'h202);
    bus.nsi = 1; bus.ndi = q[0]; bus.ssi = 1; bus.sdi = q[1];
    bus.pesi = 1; bus.pedi = q[2];
    step();
    bus.nsi = 0; bus.ssi = 0; bus.pesi = 0;
    step(); check("rr2_pe", bus.pedo, q[2]);
    step(); check("rr2_n", bus.pedo, q[0]);
    step(); check("rr2_s", bus.pedo, q[1]);
    step(); check("rr2_idle", 64'(bus.peso), 64'd0);

    // Backpressure on e: 1 held in the output register, 4 fill the pe FIFO.
    bus.ero = 0;
    for (int i = 0; i < 5; i++) q[i] = pkt(2'd3, 2'd1, 60'(32'h300 + i));
    for (int i = 0; i < 5; i++) begin
      bus.pesi = 1; bus.pedi = q[i];
      check("bp_peri_open", 64'(bus.peri), 64'd1);
      step();
    end
    bus.pesi = 0;
    check("bp_peri_full", 64'(bus.peri), 64'd0);
    check("bp_eso", 64'(bus.eso), 64'd1);
    check("bp_edo", bus.edo, q[0]);
    step(); step();
    check("bp_hold_eso", 64'(bus.eso), 64'd1);
    check("bp_hold_edo", bus.edo, q[0]);
    bus.ero = 1;
    for (int i = 1; i < 5; i++) begin
      step();
      check("bp_drain_valid", 64'(bus.eso), 64'd1);
      check("bp_drain_data", bus.edo, q[i]);
      if (i == 1) check("bp_peri_reopen", 64'(bus.peri), 64'd1);
    end
    step();
    check("bp_drain_idle", 64'(bus.eso), 64'd0);

    // Drops on the 3x3 tile: east off the edge at (2,0).
    bus2.pesi = 1; bus2.pedi = pkt(2'd3, 2'd0, 60'h400);
    step(); bus2.pesi = 0; step();
    check("drop_1", 64'(dc2), 64'd1);
    check("drop_1_no_out", 64'(bus2.eso), 64'd0);
    // South off the bottom row at (2,2).
    ry2 = 2'd2;
    bus2.pesi = 1; bus2.pedi = pkt(2'd2, 2'd3, 60'h401);
    step(); bus2.pesi = 0; step();
    check("drop_2", 64'(dc2), 64'd2);
    check("drop_2_no_out", 64'(bus2.sso), 64'd0);
    // Two heads dropping on the same edge.
    bus2.nsi = 1; bus2.ndi = pkt(2'd3, 2'd0, 60'h402);
    bus2.pesi = 1; bus2.pedi = pkt(2'd3, 2'd0, 60'h403);
    step(); bus2.nsi = 0; bus2.pesi = 0; step();
    check("drop_pair", 64'(dc2), 64'd4);
    // Continuous stream of 250 drops.
    bus2.pesi = 1; bus2.pedi = pkt(2'd3, 2'd0, 60'h404);
    repeat (250) step();
    bus2.pesi = 0; step(); step();
    check("drop_254", 64'(dc2), 64'd254);
    // Double drop from 254 saturates at 255.
    bus2.nsi = 1; bus2.pesi = 1;
    step(); bus2.nsi = 0; bus2.pesi = 0; step(); step();
    check("drop_sat", 64'(dc2), 64'd255);
    bus2.pesi = 1;
    repeat (44) step();
    bus2.pesi = 0; step(); step();
    check("drop_sat_hold", 64'(dc2), 64'd255);

    // Reset while buffered: pe output held, n FIFO half full.
    bus.pero = 0;
    for (int i = 0; i < 3; i++) begin
      bus.nsi = 1; bus.ndi = pkt(2'd1, 2'd1, 60'(32'h500 + i));
      step();
    end
    bus.nsi = 0;
    check("pre_rst_peso", 64'(bus.peso), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_peso", 64'(bus.peso), 64'd0);
    check("mid_rst_pedo", bus.pedo, 64'h0);
    check("mid_rst_nri", 64'(bus.nri), 64'd1);
    check("mid_rst_pol", 64'(pol), 64'd0);
    check("mid_rst_drop2", 64'(dc2), 64'd0);
    step();
    reset = 1'b1;
    bus.pero = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_stale", 64'({bus.nso, bus.eso, bus.sso, bus.wso, bus.peso}), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
